game_turn_fsm: RTL and testbench

GAME_TURN_FSM -- requirements
Module: game_turn_fsm

---
 rtl/game_turn_fsm_if.sv | 28 ++
 rtl/game_turn_fsm.sv | 178 +++++++++++++++++
 tb/tb_game_turn_fsm.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_turn_fsm_if.sv
// Signal bundle between the pool-game turn sequencer and the rest of the table logic.
// slave is the sequencer's view; master is the view of the block that drives it.
interface game_turn_fsm_if;
  logic       startN;
  logic       endOfRoll;
  logic       allBallsIn;
  logic       increasePoint;
  logic       init0;
  logic       whiteBallMove;
  logic       flag_hardMode;
  logic       hitEnableStateMachine;
  logic       whiteInitLoc;
  logic [3:0] score;
  logic [5:0] shotCount;
  logic [2:0] gameState;
  logic       gameOver;
  logic       win;

  modport master (
    output startN, endOfRoll, allBallsIn, increasePoint, init0, whiteBallMove, flag_hardMode,
    input  hitEnableStateMachine, whiteInitLoc, score, shotCount, gameState, gameOver, win
  );

  modport slave (
    input  startN, endOfRoll, allBallsIn, increasePoint, init0, whiteBallMove, flag_hardMode,
    output hitEnableStateMachine, whiteInitLoc, score, shotCount, gameState, gameOver, win
  );
endinterface

// File: rtl/game_turn_fsm.sv
// Pool-game turn sequencer: aim, roll/settle judgement, white-ball respot and game over.
// Optional build macro GAME_TURN_SCRATCH_PENALTY_EN: a hard-mode scratch costs one point.
module game_turn_fsm #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MAX_SHOTS     = 20
) (
  input logic            clk,
  input logic            resetN,
  game_turn_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    AIM       = 3'd1,
    ROLLING   = 3'd2,
    RESPOT    = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [5:0] SHOT_LIMIT  = 6'(MAX_SHOTS);

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  function automatic logic [3:0] sat_dec4(input logic [3:0] v);
    return (v == 4'd0) ? v : v - 4'd1;
  endfunction

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  state_t     state_r;
  state_t     roll_next_s;
  logic       start_prev_r;
  logic       start_evt_s;
  logic       settle_done_s;
  logic       point_ok_s;
  logic       penalty_s;
  logic [3:0] settle_cnt_r;
  logic [3:0] score_r;
  logic [3:0] score_next_s;
  logic [5:0] shot_r;
  logic       scratch_r;
  logic       win_r;
  logic       game_over_r;
  logic       white_init_r;

  // Start key edge, roll-settled decision point and point-scoring window
  always_comb begin
    start_evt_s   = start_prev_r & ~bus.startN;
    settle_done_s = (state_r == ROLLING) && bus.endOfRoll && (settle_cnt_r == SETTLE_LAST);
    point_ok_s    = bus.increasePoint &&
                    ((state_r == AIM) || (state_r == ROLLING) || (state_r == RESPOT));
  end

  // Outcome of a settled roll, highest priority first
  always_comb begin
    roll_next_s = AIM;
    if (bus.allBallsIn) begin
      roll_next_s = GAME_OVER;
    end else if (shot_r >= SHOT_LIMIT) begin
      roll_next_s = GAME_OVER;
    end else if (scratch_r || bus.init0) begin
      roll_next_s = RESPOT;
    end else begin
      roll_next_s = AIM;
    end
  end

`ifdef GAME_TURN_SCRATCH_PENALTY_EN
  // Hard-mode scratch is charged on the edge that enters RESPOT
  always_comb begin
    penalty_s = settle_done_s && (roll_next_s == RESPOT) && bus.flag_hardMode;
  end
`else
  logic unused_hard_mode_s;

  // Hard-mode flag has no effect in this build
  always_comb begin
    penalty_s          = 1'b0;
    unused_hard_mode_s = bus.flag_hardMode;
  end
`endif

  // Next score: cleared by a new game, a same-cycle point cancels a penalty
  always_comb begin
    score_next_s = score_r;
    if ((state_r == IDLE) && start_evt_s) begin
      score_next_s = 4'd0;
    end else if (penalty_s) begin
      score_next_s = bus.increasePoint ? score_r : sat_dec4(score_r);
    end else if (point_ok_s) begin
      score_next_s = sat_inc4(score_r);
    end else begin
      score_next_s = score_r;
    end
  end

  // Turn state machine with its counters and registered flags
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r      <= IDLE;
      start_prev_r <= 1'b1;
      settle_cnt_r <= 4'd0;
      score_r      <= 4'd0;
      shot_r       <= 6'd0;
      scratch_r    <= 1'b0;
      win_r        <= 1'b0;
      game_over_r  <= 1'b0;
      white_init_r <= 1'b0;
    end else begin
      start_prev_r <= bus.startN;
      score_r      <= score_next_s;
      white_init_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_evt_s) begin
            state_r   <= AIM;
            shot_r    <= 6'd0;
            win_r     <= 1'b0;
            scratch_r <= 1'b0;
          end
        end
        AIM: begin
          if (bus.whiteBallMove) begin
            state_r      <= ROLLING;
            shot_r       <= sat_inc6(shot_r);
            settle_cnt_r <= 4'd0;
          end
        end
        ROLLING: begin
          if (settle_done_s) begin
            state_r      <= roll_next_s;
            settle_cnt_r <= 4'd0;
            scratch_r    <= 1'b0;
            if (roll_next_s == GAME_OVER) begin
              win_r       <= bus.allBallsIn;
              game_over_r <= 1'b1;
            end
            if (roll_next_s == RESPOT) begin
              white_init_r <= 1'b1;
            end
          end else begin
            settle_cnt_r <= bus.endOfRoll ? settle_cnt_r + 4'd1 : 4'd0;
            if (bus.init0) begin
              scratch_r <= 1'b1;
            end
          end
        end
        RESPOT: begin
          state_r <= AIM;
        end
        GAME_OVER: begin
          if (start_evt_s) begin
            state_r     <= IDLE;
            game_over_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          game_over_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gameState             = state_r;
  assign bus.hitEnableStateMachine = (state_r == AIM);
  assign bus.whiteInitLoc          = white_init_r;
  assign bus.gameOver              = game_over_r;
  assign bus.win                   = win_r;
  assign bus.score                 = score_r;
  assign bus.shotCount             = shot_r;

endmodule

// File: tb/tb_game_turn_fsm.sv
// Directed bench for game_turn_fsm: two instances (default shot limit and a limit of 2)
// checked every cycle against a rule-level model, plus hand-computed checkpoints.
module tb_game_turn_fsm;

  localparam int TB_SETTLE = 4;
`ifdef GAME_TURN_SCRATCH_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk;
  logic resetN;
  int   total = 0;
  int   bad   = 0;
  bit   cmp_en = 1'b0;

  game_turn_fsm_if bus();
  game_turn_fsm_if bus2();

  game_turn_fsm #(.SETTLE_CYCLES(TB_SETTLE), .MAX_SHOTS(20)) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
  );
  game_turn_fsm #(.SETTLE_CYCLES(TB_SETTLE), .MAX_SHOTS(2)) dut2 (
    .clk(clk), .resetN(resetN), .bus(bus2)
  );

  assign bus2.startN        = bus.startN;
  assign bus2.endOfRoll     = bus.endOfRoll;
  assign bus2.allBallsIn    = bus.allBallsIn;
  assign bus2.increasePoint = bus.increasePoint;
  assign bus2.init0         = bus.init0;
  assign bus2.whiteBallMove = bus.whiteBallMove;
  assign bus2.flag_hardMode = bus.flag_hardMode;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: st uses the published state numbers; run = consecutive settled cycles this roll
  typedef struct {
    int st; int score; int shots; int win; int run; int scratch; int prev;
  } mdl_t;

  mdl_t m1, m2;

  function automatic mdl_t mrst();
    mdl_t r;
    r.st = 0; r.score = 0; r.shots = 0; r.win = 0; r.run = 0; r.scratch = 0; r.prev = 1;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int max_shots);
    mdl_t n;
    bit   st_ev;
    bit   inc;
    n     = m;
    st_ev = (m.prev == 1) && (bus.startN == 1'b0);
    inc   = (bus.increasePoint == 1'b1);
    n.prev = int'(bus.startN);
    if (inc && m.st >= 1 && m.st <= 3) n.score = (m.score < 15) ? m.score + 1 : 15;
    case (m.st)
      0: if (st_ev) begin
           n.st = 1; n.score = 0; n.shots = 0; n.win = 0; n.scratch = 0;
         end
      1: if (bus.whiteBallMove) begin
           n.st = 2; n.shots = (m.shots < 63) ? m.shots + 1 : 63; n.run = 0;
         end
      2: begin
           n.run = bus.endOfRoll ? m.run + 1 : 0;
           if (bus.init0) n.scratch = 1;
           if (n.run == TB_SETTLE) begin
             n.run = 0; n.scratch = 0;
             if (bus.allBallsIn) begin
               n.st = 4; n.win = 1;
             end else if (m.shots >= max_shots) begin
               n.st = 4; n.win = 0;
             end else if (m.scratch == 1 || bus.init0) begin
               n.st = 3;
               if (PEN && bus.flag_hardMode) n.score = inc ? m.score : ((m.score > 0) ? m.score - 1 : 0);
             end else begin
               n.st = 1;
             end
           end
         end
      3: n.st = 1;
      4: if (st_ev) n.st = 0;
      default: n.st = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m1 <= mrst();
      m2 <= mrst();
    end else begin
      m1 <= mstep(m1, 20);
      m2 <= mstep(m2, 2);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string tag, input mdl_t m, input int gs, input int sc,
                         input int sh, input int w, input int go, input int he, input int wi);
    chk({tag, "_state"}, gs, m.st);
    chk({tag, "_score"}, sc, m.score);
    chk({tag, "_shots"}, sh, m.shots);
    chk({tag, "_win"}, w, m.win);
    chk({tag, "_gameOver"}, go, (m.st == 4) ? 1 : 0);
    chk({tag, "_hitEnable"}, he, (m.st == 1) ? 1 : 0);
    chk({tag, "_whiteInitLoc"}, wi, (m.st == 3) ? 1 : 0);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_dut("d1", m1, int'(bus.gameState), int'(bus.score), int'(bus.shotCount),
              int'(bus.win), int'(bus.gameOver), int'(bus.hitEnableStateMachine),
              int'(bus.whiteInitLoc));
      cmp_dut("d2", m2, int'(bus2.gameState), int'(bus2.score), int'(bus2.shotCount),
              int'(bus2.win), int'(bus2.gameOver), int'(bus2.hitEnableStateMachine),
              int'(bus2.whiteInitLoc));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start_key();
    bus.startN = 1'b0;
    step(1);
    bus.startN = 1'b1;
  endtask

  task automatic launch();
    bus.whiteBallMove = 1'b1;
    step(1);
    bus.whiteBallMove = 1'b0;
  endtask

  task automatic settle(input int n);
    bus.endOfRoll = 1'b1;
    step(n);
    bus.endOfRoll = 1'b0;
  endtask

  task automatic point();
    bus.increasePoint = 1'b1;
    step(1);
    bus.increasePoint = 1'b0;
    step(1);
  endtask

  initial begin
    resetN = 1'b0;
    bus.startN = 1'b1; bus.endOfRoll = 1'b0; bus.allBallsIn = 1'b0; bus.increasePoint = 1'b0;
    bus.init0 = 1'b0; bus.whiteBallMove = 1'b0; bus.flag_hardMode = 1'b0;
    step(3);
    cmp_en = 1'b1;
    chk("rst_state", int'(bus.gameState), 0);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_shots", int'(bus.shotCount), 0);
    chk("rst_hit", int'(bus.hitEnableStateMachine), 0);
    resetN = 1'b1;
    step(2);

    // Normal shot: 0 -> 1 -> 2 -> 1
    start_key();
    chk("start_state", int'(bus.gameState), 1);
    chk("start_hit", int'(bus.hitEnableStateMachine), 1);
    launch();
    chk("roll_state", int'(bus.gameState), 2);
    chk("roll_hit", int'(bus.hitEnableStateMachine), 0);
    settle(4);
    chk("normal_state", int'(bus.gameState), 1);
    chk("normal_shots", int'(bus.shotCount), 1);

    // Settle glitch: 3 high, 1 low, then decision only on 4th high of second run
    launch();
    settle(3);
    step(1);
    settle(3);
    chk("glitch_wait", int'(bus.gameState), 2);
    settle(1);
    chk("glitch_done", int'(bus.gameState), 1);
    chk("limit2_state", int'(bus2.gameState), 4);
    chk("limit2_win", int'(bus2.win), 0);
    chk("limit2_shots", int'(bus2.shotCount), 2);

    repeat (3) point();
    chk("points3", int'(bus.score), 3);
    chk("limit2_score_ignored", int'(bus2.score), 0);

    // Scratch mid-roll in hard mode
    bus.flag_hardMode = 1'b1;
    launch();
    bus.init0 = 1'b1; step(1); bus.init0 = 1'b0; step(1);
    settle(4);
    chk("scratch_state", int'(bus.gameState), 3);
    chk("scratch_white", int'(bus.whiteInitLoc), 1);
    chk("scratch_score", int'(bus.score), PEN ? 2 : 3);
    step(1);
    chk("respot_exit", int'(bus.gameState), 1);
    chk("respot_white_clr", int'(bus.whiteInitLoc), 0);

    // init0 and a point on the decision cycle itself
    launch();
    settle(3);
    bus.endOfRoll = 1'b1; bus.init0 = 1'b1; bus.increasePoint = 1'b1;
    step(1);
    bus.endOfRoll = 1'b0; bus.init0 = 1'b0; bus.increasePoint = 1'b0;
    chk("dscratch_state", int'(bus.gameState), 3);
    chk("dscratch_score", int'(bus.score), PEN ? 2 : 4);
    step(1);

    // Point on a plain decision cycle
    launch();
    settle(3);
    bus.endOfRoll = 1'b1; bus.increasePoint = 1'b1;
    step(1);
    bus.endOfRoll = 1'b0; bus.increasePoint = 1'b0;
    chk("dpoint_state", int'(bus.gameState), 1);
    chk("dpoint_score", int'(bus.score), PEN ? 3 : 5);

    // Scratch with hard mode off never costs a point
    bus.flag_hardMode = 1'b0;
    launch();
    bus.init0 = 1'b1; step(1); bus.init0 = 1'b0;
    settle(4);
    chk("easy_scratch_state", int'(bus.gameState), 3);
    chk("easy_scratch_score", int'(bus.score), PEN ? 3 : 5);
    step(1);

    // allBallsIn outranks a same-cycle scratch
    bus.allBallsIn = 1'b1;
    launch();
    settle(3);
    bus.endOfRoll = 1'b1; bus.init0 = 1'b1;
    step(1);
    bus.endOfRoll = 1'b0; bus.init0 = 1'b0; bus.allBallsIn = 1'b0;
    chk("winA_state", int'(bus.gameState), 4);
    chk("winA_win", int'(bus.win), 1);
    chk("winA_over", int'(bus.gameOver), 1);
    chk("winA_shots", int'(bus.shotCount), 7);

    // Held-low startN gives one event only
    bus.startN = 1'b0;
    step(3);
    chk("level_low_state", int'(bus.gameState), 0);
    bus.startN = 1'b1;
    step(1);
    start_key();
    chk("newgame_state", int'(bus.gameState), 1);
    chk("newgame_score", int'(bus.score), 0);
    chk("newgame_win", int'(bus.win), 0);

    // Win game: three points then all balls in
    repeat (3) point();
    launch();
    bus.allBallsIn = 1'b1;
    settle(4);
    bus.allBallsIn = 1'b0;
    chk("winB_state", int'(bus.gameState), 4);
    chk("winB_score", int'(bus.score), 3);
    chk("winB_win", int'(bus.win), 1);
    point();
    chk("over_point_ignored", int'(bus.score), 3);
    start_key();
    chk("over_to_idle", int'(bus.gameState), 0);
    point();
    chk("idle_point_ignored", int'(bus.score), 3);
    start_key();
    chk("restart_score", int'(bus.score), 0);

    // Saturation, then asynchronous reset mid-roll
    repeat (17) point();
    chk("sat_score", int'(bus.score), 15);
    launch();
    bus.endOfRoll = 1'b1;
    step(2);
    resetN = 1'b0;
    #1;
    chk("async_state", int'(bus.gameState), 0);
    chk("async_score", int'(bus.score), 0);
    chk("async_shots", int'(bus.shotCount), 0);
    bus.endOfRoll = 1'b0;
    step(2);
    resetN = 1'b1;
    step(3);
    chk("post_reset_wait", int'(bus.gameState), 0);

    // Default shot limit: the 20th roll ends the game without a win
    start_key();
    for (int i = 0; i < 20; i++) begin
      launch();
      settle(4);
    end
    chk("limit20_state", int'(bus.gameState), 4);
    chk("limit20_shots", int'(bus.shotCount), 20);
    chk("limit20_win", int'(bus.win), 0);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
